// File: rtl/piano_pkg.sv
// Shared definitions for the piano display: key state encoding and colour format.
package piano_pkg;
    localparam int COLOR_W = 24;
    localparam int CHAN_W  = 8;

    typedef enum logic [1:0] {
        KEY_IDLE     = 2'd0,
        KEY_DEBOUNCE = 2'd1,
        KEY_PRESSED  = 2'd2,
        KEY_FADE     = 2'd3
    } key_state_e;
endpackage

// File: rtl/key_fsm.sv
// One key's debounce/press/fade state machine and its registered fill colour.
// All state moves only on frame ticks so the colour is stable across a frame.
module key_fsm
    import piano_pkg::*;
#(
    parameter logic [COLOR_W-1:0] IDLE_COLOR      = 24'hFF_FF_FF,
    parameter logic [COLOR_W-1:0] PRESS_COLOR     = 24'h00_80_FF,
    parameter int                 DEBOUNCE_FRAMES = 2,
    parameter int                 FADE_SHIFT      = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               hit,
    output logic [COLOR_W-1:0] color,
    output logic               down,
    output logic               note_on
);
    localparam int LMAX = 1 << FADE_SHIFT;
    localparam int LW   = FADE_SHIFT + 1;
    localparam int CW   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int AW   = CHAN_W + FADE_SHIFT + 1;

    localparam logic [LW-1:0] LVL_MAX  = LW'(LMAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    key_state_e    state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] lvl;
    logic [LW-1:0] lvl_dn;

    // Per-channel linear blend; truncation keeps both endpoints exact.
    function automatic logic [COLOR_W-1:0] blend(input logic [LW-1:0] l);
        logic [AW-1:0]      acc;
        logic [COLOR_W-1:0] res;
        res = '0;
        for (int c = 0; c < COLOR_W / CHAN_W; c++) begin
            acc = AW'(PRESS_COLOR[CHAN_W*c +: CHAN_W]) * AW'(l)
                + AW'(IDLE_COLOR[CHAN_W*c +: CHAN_W]) * (AW'(LMAX) - AW'(l));
            res[CHAN_W*c +: CHAN_W] = acc[FADE_SHIFT +: CHAN_W];
        end
        return res;
    endfunction

    always_comb begin
        lvl_dn = (state == KEY_PRESSED) ? LVL_MAX - LW'(1) : lvl - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= KEY_IDLE;
            cnt     <= '0;
            lvl     <= '0;
            color   <= IDLE_COLOR;
            down    <= 1'b0;
            note_on <= 1'b0;
        end else begin
            note_on <= 1'b0;
            if (tick) begin
                case (state)
                    KEY_IDLE: begin
                        if (hit) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state   <= KEY_PRESSED;
                                lvl     <= LVL_MAX;
                                color   <= PRESS_COLOR;
                                down    <= 1'b1;
                                note_on <= 1'b1;
                            end else begin
                                state <= KEY_DEBOUNCE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    KEY_DEBOUNCE: begin
                        if (!hit) begin
                            state <= KEY_IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= KEY_PRESSED;
                            cnt     <= '0;
                            lvl     <= LVL_MAX;
                            color   <= PRESS_COLOR;
                            down    <= 1'b1;
                            note_on <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    KEY_PRESSED, KEY_FADE: begin
                        if (hit && state == KEY_FADE) begin
                            // Retrigger from a fade skips debounce.
                            state   <= KEY_PRESSED;
                            lvl     <= LVL_MAX;
                            color   <= PRESS_COLOR;
                            down    <= 1'b1;
                            note_on <= 1'b1;
                        end else if (!hit || state == KEY_FADE) begin
                            state <= (lvl_dn == '0) ? KEY_IDLE : KEY_FADE;
                            lvl   <= lvl_dn;
                            color <= blend(lvl_dn);
                            down  <= 1'b0;
                        end
                    end
                    default: state <= KEY_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/key_color_ctrl.sv
// Per-key highlight controller: frame tick from vsync falling edge, one key_fsm per key.
module key_color_ctrl
    import piano_pkg::*;
#(
    parameter int                 NUM_KEYS        = 8,
    parameter logic [COLOR_W-1:0] IDLE_COLOR      = 24'hFF_FF_FF,
    parameter logic [COLOR_W-1:0] PRESS_COLOR     = 24'h00_80_FF,
    parameter int                 DEBOUNCE_FRAMES = 2,
    parameter int                 FADE_SHIFT      = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          vsync,
    input  logic [NUM_KEYS-1:0]           key_hit,
    output logic [NUM_KEYS*COLOR_W-1:0]   key_color,
    output logic [NUM_KEYS-1:0]           key_down,
    output logic [NUM_KEYS-1:0]           note_on
);
    logic vsync_q;
    logic tick;

    always_ff @(posedge clock) begin
        if (reset) vsync_q <= 1'b0;
        else       vsync_q <= vsync;
    end

    assign tick = vsync_q & ~vsync;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_fsm #(
            .IDLE_COLOR      (IDLE_COLOR),
            .PRESS_COLOR     (PRESS_COLOR),
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
            .FADE_SHIFT      (FADE_SHIFT)
        ) u_key (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick),
            .hit     (key_hit[i]),
            .color   (key_color[COLOR_W*i +: COLOR_W]),
            .down    (key_down[i]),
            .note_on (note_on[i])
        );
    end
endmodule
